minigame_sequencer: RTL

MINIGAME_SEQUENCER -- requirements
Module: minigame_sequencer

---
 rtl/minigame_pkg.sv | 17 +
 rtl/tick_prescaler.sv | 28 ++
 rtl/minigame_sequencer.sv | 96 +++++++++
 3 files changed

// File: rtl/minigame_pkg.sv
// Shared types for the minigame sequencer: FSM state encoding and BCD digit width.
package minigame_pkg;

    localparam int STATE_W = 3;
    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        PLAY   = 3'd2,
        JUDGE  = 3'd3,
        FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides MCLK down to a one-cycle game tick; counts only while run is high.
module tick_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic MCLK,
    input  logic RESET,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = run && (count == LAST);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge MCLK) begin
        if (RESET || clear) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/minigame_sequencer.sv
// Session sequencer: runs NUM_ROUNDS timed mini-game rounds and tallies successes.
module minigame_sequencer
    import minigame_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int TIME_LIMIT = 9,
    parameter int NUM_ROUNDS = 5
) (
    input  logic               MCLK,
    input  logic               RESET,
    input  logic               start,
    input  logic               game_done,
    output logic               game_enable,
    output logic               busy,
    output logic [DIGIT_W-1:0] round_bcd,
    output logic [DIGIT_W-1:0] score_bcd,
    output logic [DIGIT_W-1:0] timer_bcd,
    output logic               result_valid,
    output logic               all_clear
);

    localparam digit_t TIME_DIGIT   = digit_t'(TIME_LIMIT);
    localparam digit_t ROUNDS_DIGIT = digit_t'(NUM_ROUNDS);

    state_t state, state_next;
    digit_t round, score, timer;
    logic   win;
    logic   tick;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .MCLK (MCLK),
        .RESET(RESET),
        .clear(state == ARM),
        .run  (state == PLAY),
        .tick (tick)
    );

    // NOTE: defaults first so no path through the case leaves a latch behind.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = ARM;
            ARM:     state_next = PLAY;
            PLAY:    if (game_done || (tick && timer == '0)) state_next = JUDGE;
            JUDGE:   state_next = (round + digit_t'(1) == ROUNDS_DIGIT) ? FINISH : ARM;
            FINISH:  if (start) state_next = ARM;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state        <= IDLE;
            round        <= '0;
            score        <= '0;
            timer        <= '0;
            win          <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_next;
            result_valid <= (state == JUDGE) && (state_next == FINISH);

            // The timer is preloaded on the way into ARM so ARM already shows a full round.
            if (state_next == ARM || state == ARM) begin
                timer <= TIME_DIGIT;
            end else if (state == PLAY && tick && timer != '0) begin
                timer <= timer - digit_t'(1);
            end

            unique case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        round <= '0;
                        score <= '0;
                    end
                end
                PLAY:  win <= game_done;
                JUDGE: begin
                    round <= round + digit_t'(1);
                    if (win) score <= score + digit_t'(1);
                end
                default: ;
            endcase
        end
    end

    assign game_enable = (state == PLAY);
    assign busy        = (state == ARM) || (state == PLAY) || (state == JUDGE);
    assign round_bcd   = round;
    assign score_bcd   = score;
    assign timer_bcd   = busy ? timer : '0;
    assign all_clear   = (state == FINISH) && (score == ROUNDS_DIGIT);

endmodule
